// File: rtl/rr_mux4_arbiter.sv
// rtl/rr_mux4_arbiter.sv - round-robin owner selection and burst sequencing for a shared 4:1 data mux.
module rr_mux4_arbiter #(
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        req,
  input  logic [DATA_W-1:0] din0,
  input  logic [DATA_W-1:0] din1,
  input  logic [DATA_W-1:0] din2,
  input  logic [DATA_W-1:0] din3,
  input  logic              out_ready,
  output logic [3:0]        grant,
  output logic [1:0]        select_line,
  output logic              out_valid,
  output logic [DATA_W-1:0] dout,
  output logic              busy
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  localparam logic [3:0] LAST_BEAT = 4'(MAX_BURST - 1);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_grant;
  logic [3:0] w_grant_nxt;
  logic [1:0] r_sel;
  logic [1:0] w_sel_nxt;
  logic [1:0] r_ptr;
  logic [1:0] w_ptr_nxt;
  logic [3:0] r_beat_cnt;
  logic [3:0] w_beat_cnt_nxt;

  logic       w_found;
  logic [1:0] w_pick;
  logic       w_busy;
  logic       w_out_valid;
  logic       w_xfer;
  logic       w_last_beat;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_grant    <= 4'b0000;
      r_sel      <= 2'b00;
      r_ptr      <= 2'b00;
      r_beat_cnt <= 4'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_grant    <= w_grant_nxt;
      r_sel      <= w_sel_nxt;
      r_ptr      <= w_ptr_nxt;
      r_beat_cnt <= w_beat_cnt_nxt;
    end
  end

  // First requester at or after the rotating pointer wins.
  always_comb begin
    logic [1:0] v_idx;
    w_found = 1'b0;
    w_pick  = r_ptr;
    for (int k = 0; k < 4; k++) begin
      v_idx = r_ptr + 2'(k);
      if (!w_found && req[v_idx]) begin
        w_found = 1'b1;
        w_pick  = v_idx;
      end
    end
  end

  assign w_busy      = (r_state == S_GRANT);
  assign w_out_valid = w_busy & req[r_sel];
  assign w_xfer      = w_out_valid & out_ready;
  assign w_last_beat = (r_beat_cnt == LAST_BEAT);

  always_comb begin
    w_state_nxt    = r_state;
    w_grant_nxt    = r_grant;
    w_sel_nxt      = r_sel;
    w_ptr_nxt      = r_ptr;
    w_beat_cnt_nxt = r_beat_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_nxt    = S_GRANT;
          w_grant_nxt    = 4'b0001 << w_pick;
          w_sel_nxt      = w_pick;
          w_beat_cnt_nxt = 4'd0;
        end
      end
      S_GRANT: begin
        // Release on the final beat of a burst or when the owner withdraws.
        if ((w_xfer && w_last_beat) || !req[r_sel]) begin
          w_state_nxt    = S_IDLE;
          w_grant_nxt    = 4'b0000;
          w_ptr_nxt      = r_sel + 2'd1;
          w_beat_cnt_nxt = 4'd0;
        end else if (w_xfer) begin
          w_beat_cnt_nxt = r_beat_cnt + 4'd1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_grant_nxt = 4'b0000;
      end
    endcase
  end

  always_comb begin
    dout = '0;
    if (w_busy) begin
      case (r_sel)
        2'd0:    dout = din0;
        2'd1:    dout = din1;
        2'd2:    dout = din2;
        default: dout = din3;
      endcase
    end
  end

  assign grant       = r_grant;
  assign select_line = r_sel;
  assign out_valid   = w_out_valid;
  assign busy        = w_busy;

endmodule

// File: tb/tb_rr_mux4_arbiter.sv
// tb/tb_rr_mux4_arbiter.sv - scoreboard bench for rr_mux4_arbiter (default burst and single-beat instances).
module tb_rr_mux4_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [7:0] din0, din1, din2, din3;
  logic       out_ready;

  logic [3:0] grant_a, grant_b;
  logic [1:0] sel_a, sel_b;
  logic       ov_a, ov_b, busy_a, busy_b;
  logic [7:0] dout_a, dout_b;

  logic [9:0] sb_a[$];
  logic [9:0] sb_b[$];
  bit         mon_a_en = 1'b0;
  bit         mon_b_en = 1'b0;
  logic       prev_busy_b = 1'b0;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  rr_mux4_arbiter #(.DATA_W(8), .MAX_BURST(4)) u_dut_a (
    .clk(clk), .rst(rst), .req(req),
    .din0(din0), .din1(din1), .din2(din2), .din3(din3),
    .out_ready(out_ready), .grant(grant_a), .select_line(sel_a),
    .out_valid(ov_a), .dout(dout_a), .busy(busy_a)
  );

  rr_mux4_arbiter #(.DATA_W(8), .MAX_BURST(1)) u_dut_b (
    .clk(clk), .rst(rst), .req(req),
    .din0(din0), .din1(din1), .din2(din2), .din3(din3),
    .out_ready(out_ready), .grant(grant_b), .select_line(sel_b),
    .out_valid(ov_b), .dout(dout_b), .busy(busy_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [3:0] onehot(input logic [1:0] idx);
    onehot = 4'b0001 << idx;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req       = 4'b0000;
    out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_drain(input bit use_b);
    bit done = 1'b0;
    for (int n = 0; n < 60 && !done; n++) begin
      @(posedge clk);
      if ((use_b ? sb_b.size() : sb_a.size()) == 0) done = 1'b1;
    end
    check(use_b ? "b_drain_timeout" : "a_drain_timeout", {31'd0, done}, 32'd1);
    if (!done) begin
      sb_a.delete();
      sb_b.delete();
    end
    #1;
  endtask

  always @(negedge clk) begin : mon_a
    logic [9:0] e;
    if (mon_a_en && ov_a === 1'b1 && out_ready === 1'b1) begin
      if (sb_a.size() == 0) check("a_extra_beat", 32'd1, 32'd0);
      else begin
        e = sb_a.pop_front();
        check("a_sel", {30'd0, sel_a}, {30'd0, e[9:8]});
        check("a_grant", {28'd0, grant_a}, {28'd0, onehot(e[9:8])});
        check("a_dout", {24'd0, dout_a}, {24'd0, e[7:0]});
      end
    end
  end

  always @(negedge clk) begin : mon_b
    logic [9:0] e;
    if (mon_b_en && ov_b === 1'b1 && out_ready === 1'b1) begin
      if (sb_b.size() == 0) check("b_extra_beat", 32'd1, 32'd0);
      else begin
        e = sb_b.pop_front();
        check("b_sel", {30'd0, sel_b}, {30'd0, e[9:8]});
        check("b_grant", {28'd0, grant_b}, {28'd0, onehot(e[9:8])});
        check("b_dout", {24'd0, dout_b}, {24'd0, e[7:0]});
        check("b_bubble", {31'd0, prev_busy_b}, 32'd0);
      end
    end
    prev_busy_b <= busy_b;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req = 4'b1111; out_ready = 1'b0;
    din0 = 8'h00; din1 = 8'h00; din2 = 8'h00; din3 = 8'h00;

    // Reset with all requests asserted
    tick();
    tick();
    @(negedge clk);
    check("rst_grant", {28'd0, grant_a}, 32'd0);
    check("rst_sel", {30'd0, sel_a}, 32'd0);
    check("rst_valid", {31'd0, ov_a}, 32'd0);
    check("rst_dout", {24'd0, dout_a}, 32'd0);
    check("rst_busy", {31'd0, busy_a}, 32'd0);
    check("rst_busy_b", {31'd0, busy_b}, 32'd0);

    // Single requester, full 4-beat burst, then ptr=3
    do_reset();
    mon_a_en = 1'b1;
    din2 = 8'hA5; req = 4'b0100; out_ready = 1'b1;
    repeat (4) sb_a.push_back({2'd2, 8'hA5});
    @(negedge clk);
    check("t2_bubble_busy", {31'd0, busy_a}, 32'd0);
    check("t2_bubble_grant", {28'd0, grant_a}, 32'd0);
    wait_drain(1'b0);
    req = 4'b1111; out_ready = 1'b0; din3 = 8'h96;
    @(negedge clk);
    check("t2_release_busy", {31'd0, busy_a}, 32'd0);
    check("t2_release_grant", {28'd0, grant_a}, 32'd0);
    check("t2_release_valid", {31'd0, ov_a}, 32'd0);
    tick();
    @(negedge clk);
    check("t2_ptr3_grant", {28'd0, grant_a}, 32'h8);
    check("t2_ptr3_sel", {30'd0, sel_a}, 32'd3);
    check("t2_ptr3_dout", {24'd0, dout_a}, 32'h96);

    // Per-beat rotation with wrap on the MAX_BURST=1 instance
    do_reset();
    mon_a_en = 1'b0;
    din0 = 8'h11; din1 = 8'h22; din2 = 8'h33; din3 = 8'h44;
    req = 4'b1111; out_ready = 1'b1;
    sb_b.push_back({2'd0, 8'h11});
    sb_b.push_back({2'd1, 8'h22});
    sb_b.push_back({2'd2, 8'h33});
    sb_b.push_back({2'd3, 8'h44});
    sb_b.push_back({2'd0, 8'h11});
    mon_b_en = 1'b1;
    wait_drain(1'b1);
    mon_b_en = 1'b0;

    // Stall holds the owner and its data, then 4 beats
    do_reset();
    mon_a_en = 1'b1;
    din1 = 8'h3C; req = 4'b0010; out_ready = 1'b0;
    tick();
    repeat (3) begin
      @(negedge clk);
      check("t4_stall_valid", {31'd0, ov_a}, 32'd1);
      check("t4_stall_dout", {24'd0, dout_a}, 32'h3C);
      check("t4_stall_grant", {28'd0, grant_a}, 32'h2);
      tick();
    end
    out_ready = 1'b1;
    repeat (4) sb_a.push_back({2'd1, 8'h3C});
    wait_drain(1'b0);
    req = 4'b0000;
    @(negedge clk);
    check("t4_done_busy", {31'd0, busy_a}, 32'd0);
    check("t4_done_valid", {31'd0, ov_a}, 32'd0);
    repeat (3) tick();

    // Early drop by requester 3, ptr wraps to 0
    do_reset();
    din3 = 8'h5A; din0 = 8'h77; req = 4'b1000; out_ready = 1'b1;
    repeat (2) sb_a.push_back({2'd3, 8'h5A});
    wait_drain(1'b0);
    req = 4'b0011; out_ready = 1'b0;
    @(negedge clk);
    check("t5_drop_valid", {31'd0, ov_a}, 32'd0);
    check("t5_drop_busy", {31'd0, busy_a}, 32'd1);
    check("t5_drop_grant", {28'd0, grant_a}, 32'h8);
    tick();
    @(negedge clk);
    check("t5_idle_busy", {31'd0, busy_a}, 32'd0);
    check("t5_idle_grant", {28'd0, grant_a}, 32'd0);
    tick();
    @(negedge clk);
    check("t5_next_grant", {28'd0, grant_a}, 32'h1);
    check("t5_next_sel", {30'd0, sel_a}, 32'd0);
    check("t5_next_valid", {31'd0, ov_a}, 32'd1);
    check("t5_next_dout", {24'd0, dout_a}, 32'h77);

    // Reset during the second beat of a requester-2 burst
    do_reset();
    din2 = 8'hC3; req = 4'b0100; out_ready = 1'b1;
    repeat (2) sb_a.push_back({2'd2, 8'hC3});
    tick();
    tick();
    rst = 1'b1;
    tick();
    @(negedge clk);
    check("t6_rst_grant", {28'd0, grant_a}, 32'd0);
    check("t6_rst_sel", {30'd0, sel_a}, 32'd0);
    check("t6_rst_valid", {31'd0, ov_a}, 32'd0);
    check("t6_rst_dout", {24'd0, dout_a}, 32'd0);
    check("t6_rst_busy", {31'd0, busy_a}, 32'd0);
    check("t6_beats_seen", sb_a.size(), 32'd0);
    rst = 1'b0; req = 4'b0000;
    repeat (3) tick();
    req = 4'b1111; out_ready = 1'b0;
    tick();
    @(negedge clk);
    check("t6_ptr0_grant", {28'd0, grant_a}, 32'h1);
    check("t6_ptr0_sel", {30'd0, sel_a}, 32'd0);

    check("final_sb_a", sb_a.size(), 32'd0);
    check("final_sb_b", sb_b.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
